// File: rtl/order_timer_pkg.sv
// Shared types and constants for the order timer: FSM state encoding, dish codes,
// default preparation times and a small OP population-count helper.
package order_timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COOK,
    ST_DONE,
    ST_RELEASE,
    ST_WAIT_CLR
  } state_t;

  localparam logic [1:0] DISH_1 = 2'd0;
  localparam logic [1:0] DISH_2 = 2'd1;
  localparam logic [1:0] DISH_3 = 2'd2;
  localparam logic [1:0] DISH_4 = 2'd3;

  localparam int unsigned T1_DEF    = 8;
  localparam int unsigned T2_DEF    = 12;
  localparam int unsigned T3_DEF    = 16;
  localparam int unsigned T4_DEF    = 20;
  localparam int unsigned TW_DEF    = 8;
  localparam int unsigned CNT_W_DEF = 8;

  // Number of menu option lines asserted at once.
  function automatic logic [2:0] op_count(input logic [3:0] ops);
    return 3'(ops[0]) + 3'(ops[1]) + 3'(ops[2]) + 3'(ops[3]);
  endfunction

endpackage

// File: rtl/prep_counter.sv
// Loadable down-counter that stops at zero and flags the last counted cycle (value==1).
module prep_counter
  import order_timer_pkg::*;
#(
  parameter int unsigned TW = TW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  input  logic          i_en,
  output logic [TW-1:0] o_count,
  output logic          o_one_c
);

  logic [TW-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - TW'(1);
    end
  end

  assign o_count = r_count;
  assign o_one_c = (r_count == TW'(1));

endmodule

// File: rtl/order_timer.sv
// Times preparation of the dish picked by the menu FSM, presents READY, then pulses CLC.
// Optional macro ORDER_TIMER_AUTOACK_EN: DONE self-acknowledges after HOLD cycles.
module order_timer
  import order_timer_pkg::*;
#(
  parameter int unsigned T1    = T1_DEF,
  parameter int unsigned T2    = T2_DEF,
  parameter int unsigned T3    = T3_DEF,
  parameter int unsigned T4    = T4_DEF,
  parameter int unsigned TW    = TW_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
`ifdef ORDER_TIMER_AUTOACK_EN
  ,
  parameter int unsigned HOLD  = 4
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             OP1,
  input  logic             OP2,
  input  logic             OP3,
  input  logic             OP4,
  input  logic             CANCEL,
  input  logic             ACK,
  output logic             CLC,
  output logic             BUSY,
  output logic             READY,
  output logic             ERR,
  output logic [1:0]       DISH,
  output logic [TW-1:0]    REMAIN,
  output logic [CNT_W-1:0] ORDERS
);

  state_t           r_state;
  logic             r_clc;
  logic             r_busy;
  logic             r_ready;
  logic             r_err;
  logic [1:0]       r_dish;
  logic [CNT_W-1:0] r_orders;

  logic [3:0]    w_ops;
  logic [2:0]    w_op_cnt;
  logic          w_one_hot;
  logic          w_multi;
  logic [1:0]    w_sel_dish;
  logic [TW-1:0] w_sel_time;
  logic          w_rem_load;
  logic [TW-1:0] w_rem_val;
  logic          w_rem_en;
  logic [TW-1:0] w_remain;
  logic          w_rem_one;
  logic          w_auto_ack;

  assign w_ops     = {OP4, OP3, OP2, OP1};
  assign w_op_cnt  = op_count(w_ops);
  assign w_one_hot = (w_op_cnt == 3'd1);
  assign w_multi   = (w_op_cnt > 3'd1);

  // Dish code and prep time for a one-hot selection.
  always_comb begin
    w_sel_dish = DISH_1;
    w_sel_time = TW'(T1);
    if (w_ops[1]) begin
      w_sel_dish = DISH_2;
      w_sel_time = TW'(T2);
    end else if (w_ops[2]) begin
      w_sel_dish = DISH_3;
      w_sel_time = TW'(T3);
    end else if (w_ops[3]) begin
      w_sel_dish = DISH_4;
      w_sel_time = TW'(T4);
    end
  end

  // REMAIN is loaded on start, cleared on cancel, counts down while cooking.
  assign w_rem_load = ((r_state == ST_IDLE) && w_one_hot) || ((r_state == ST_COOK) && CANCEL);
  assign w_rem_val  = (r_state == ST_IDLE) ? w_sel_time : '0;
  assign w_rem_en   = (r_state == ST_COOK);

  prep_counter #(.TW(TW)) u_remain (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_rem_load),
    .i_load_val (w_rem_val),
    .i_en       (w_rem_en),
    .o_count    (w_remain),
    .o_one_c    (w_rem_one)
  );

`ifdef ORDER_TIMER_AUTOACK_EN
  logic          w_hold_load;
  logic [TW-1:0] w_hold_cnt;
  logic          w_hold_one;

  assign w_hold_load = (r_state == ST_COOK) && !CANCEL && w_rem_one;

  prep_counter #(.TW(TW)) u_hold (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_hold_load),
    .i_load_val (TW'(HOLD)),
    .i_en       (r_state == ST_DONE),
    .o_count    (w_hold_cnt),
    .o_one_c    (w_hold_one)
  );

  // A zero HOLD degenerates to a single READY cycle.
  assign w_auto_ack = (r_state == ST_DONE) && (w_hold_one || (w_hold_cnt == '0));
`else
  assign w_auto_ack = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_clc    <= 1'b0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b0;
      r_err    <= 1'b0;
      r_dish   <= DISH_1;
      r_orders <= '0;
    end else begin
      r_clc <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_one_hot) begin
            r_state <= ST_COOK;
            r_busy  <= 1'b1;
            r_dish  <= w_sel_dish;
          end else if (w_multi) begin
            r_err <= 1'b1;
          end
        end
        ST_COOK: begin
          if (CANCEL) begin
            r_state <= ST_RELEASE;
            r_busy  <= 1'b0;
            r_clc   <= 1'b1;
          end else if (w_rem_one) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          if (ACK || w_auto_ack) begin
            r_state  <= ST_RELEASE;
            r_ready  <= 1'b0;
            r_orders <= r_orders + CNT_W'(1);
            r_clc    <= 1'b1;
          end
        end
        ST_RELEASE: begin
          r_state <= ST_WAIT_CLR;
        end
        ST_WAIT_CLR: begin
          // Hold off until the menu drops its selection so it cannot restart us.
          if (w_ops == 4'b0000) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign CLC    = r_clc;
  assign BUSY   = r_busy;
  assign READY  = r_ready;
  assign ERR    = r_err;
  assign DISH   = r_dish;
  assign REMAIN = w_remain;
  assign ORDERS = r_orders;

endmodule

// File: tb/tb_order_timer.sv
// Self-checking bench for order_timer: vector table, corner-case sequences and a
// randomized run against a behavioural model of the order flow.
module tb_order_timer;

  localparam int unsigned TW    = 8;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned HOLD  = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       ops;
  logic             cancel;
  logic             ack;
  logic             clc;
  logic             busy;
  logic             ready;
  logic             err;
  logic [1:0]       dish;
  logic [TW-1:0]    remain;
  logic [CNT_W-1:0] orders;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  order_timer dut (
    .clk    (clk),
    .reset  (reset),
    .OP1    (ops[0]),
    .OP2    (ops[1]),
    .OP3    (ops[2]),
    .OP4    (ops[3]),
    .CANCEL (cancel),
    .ACK    (ack),
    .CLC    (clc),
    .BUSY   (busy),
    .READY  (ready),
    .ERR    (err),
    .DISH   (dish),
    .REMAIN (remain),
    .ORDERS (orders)
  );

  typedef struct {
    logic [3:0] op;
    logic       cancel;
    logic       ack;
    int         n;
    logic       busy;
    logic       ready;
    logic       clc;
    logic       err;
    logic [1:0] dish;
    int         remain;
    int         orders;
  } vec_t;

  vec_t tab[19];

  // Behavioural model: phase 0 idle, 1 cooking, 2 ready, 3 release, 4 wait for menu clear.
  int m_phase, m_remain, m_age, m_dish, m_orders;
  bit m_err;

  function automatic int prep_time(input int d);
    return 8 + 4 * d;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_remain = 0; m_age = 0; m_dish = 0; m_orders = 0; m_err = 0;
  endtask

  task automatic model_step(input logic [3:0] o, input bit c, input bit a);
    int nsel;
    bit auto_ack;
    nsel = $countones(o);
    auto_ack = 1'b0;
    case (m_phase)
      0: begin
        if (nsel == 1) begin
          for (int d = 0; d < 4; d++) if (o[d]) m_dish = d;
          m_remain = prep_time(m_dish);
          m_phase  = 1;
        end else if (nsel > 1) begin
          m_err = 1'b1;
        end
      end
      1: begin
        if (c) begin
          m_phase = 3; m_remain = 0;
        end else begin
          m_remain = m_remain - 1;
          if (m_remain == 0) begin
            m_phase = 2; m_age = 0;
          end
        end
      end
      2: begin
        m_age = m_age + 1;
`ifdef ORDER_TIMER_AUTOACK_EN
        auto_ack = (m_age >= HOLD);
`endif
        if (a || auto_ack) begin
          m_phase  = 3;
          m_orders = (m_orders + 1) % (1 << CNT_W);
        end
      end
      3: m_phase = 4;
      default: if (o == 4'b0000) m_phase = 0;
    endcase
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; ops = 4'b0; cancel = 1'b0; ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Place one OP1 order and acknowledge it as soon as READY shows.
  task automatic do_order();
    int k;
    ops = 4'b0001; tick(1); ops = 4'b0000;
    k = 0;
    while (ready !== 1'b1 && k < 30) begin tick(1); k++; end
    if (k >= 30) chk("order ready timeout", 32'(k), 32'd0);
    ack = 1'b1; tick(1); ack = 1'b0; tick(2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, rc, o_before;
    bit seen_ready;
    logic [31:0] exp_v, act_v;

    tab[0]  = '{4'b0010, 0, 0,  1, 1, 0, 0, 0, 2'd1, 12, 0};
    tab[1]  = '{4'b0000, 0, 0, 11, 1, 0, 0, 0, 2'd1,  1, 0};
    tab[2]  = '{4'b0000, 0, 0,  1, 0, 1, 0, 0, 2'd1,  0, 0};
    tab[3]  = '{4'b0000, 0, 0,  2, 0, 1, 0, 0, 2'd1,  0, 0};
    tab[4]  = '{4'b0000, 0, 1,  1, 0, 0, 1, 0, 2'd1,  0, 1};
    tab[5]  = '{4'b0000, 0, 0,  1, 0, 0, 0, 0, 2'd1,  0, 1};
    tab[6]  = '{4'b0000, 0, 0,  1, 0, 0, 0, 0, 2'd1,  0, 1};
    tab[7]  = '{4'b0101, 0, 0,  1, 0, 0, 0, 1, 2'd1,  0, 1};
    tab[8]  = '{4'b0001, 0, 0,  1, 1, 0, 0, 1, 2'd0,  8, 1};
    tab[9]  = '{4'b0000, 0, 0,  7, 1, 0, 0, 1, 2'd0,  1, 1};
    tab[10] = '{4'b0000, 0, 0,  1, 0, 1, 0, 1, 2'd0,  0, 1};
    tab[11] = '{4'b0000, 0, 1,  1, 0, 0, 1, 1, 2'd0,  0, 2};
    tab[12] = '{4'b0000, 0, 0,  2, 0, 0, 0, 1, 2'd0,  0, 2};
    tab[13] = '{4'b0100, 0, 0,  1, 1, 0, 0, 1, 2'd2, 16, 2};
    tab[14] = '{4'b0000, 0, 0, 15, 1, 0, 0, 1, 2'd2,  1, 2};
    tab[15] = '{4'b0000, 1, 0,  1, 0, 0, 1, 1, 2'd2,  0, 2};
    tab[16] = '{4'b0000, 0, 0,  2, 0, 0, 0, 1, 2'd2,  0, 2};
    tab[17] = '{4'b0000, 0, 1,  3, 0, 0, 0, 1, 2'd2,  0, 2};
    tab[18] = '{4'b0000, 1, 0,  2, 0, 0, 0, 1, 2'd2,  0, 2};

    do_reset();
    chk("reset state", {28'(0), clc, busy, ready, err}, 32'd0);
    chk("reset dish/remain/orders", {14'(0), dish, remain, orders}, 32'd0);

    // Vector table: OP2 order with late ACK, error then OP1 order, cancel on last cycle.
    for (int i = 0; i < 19; i++) begin
      ops = tab[i].op; cancel = tab[i].cancel; ack = tab[i].ack;
      tick(tab[i].n);
      chk($sformatf("row%0d busy", i),   32'(busy),   32'(tab[i].busy));
      chk($sformatf("row%0d ready", i),  32'(ready),  32'(tab[i].ready));
      chk($sformatf("row%0d clc", i),    32'(clc),    32'(tab[i].clc));
      chk($sformatf("row%0d err", i),    32'(err),    32'(tab[i].err));
      chk($sformatf("row%0d dish", i),   32'(dish),   32'(tab[i].dish));
      chk($sformatf("row%0d remain", i), 32'(remain), 32'(tab[i].remain));
      chk($sformatf("row%0d orders", i), 32'(orders), 32'(tab[i].orders));
    end
    cancel = 1'b0; ack = 1'b0;

    // OP4 cancelled at REMAIN=5.
    do_reset();
    o_before = int'(orders);
    seen_ready = 1'b0;
    ops = 4'b1000; tick(1); ops = 4'b0000;
    chk("t2 start remain", 32'(remain), 32'd20);
    chk("t2 start dish", 32'(dish), 32'd3);
    k = 0;
    while (remain !== 8'd5 && k < 40) begin tick(1); k++; seen_ready |= ready; end
    chk("t2 cycles to remain5", 32'(k), 32'd15);
    cancel = 1'b1; tick(1); cancel = 1'b0;
    chk("t2 clc", 32'(clc), 32'd1);
    chk("t2 busy", 32'(busy), 32'd0);
    seen_ready |= ready;
    tick(1);
    chk("t2 clc single", 32'(clc), 32'd0);
    seen_ready |= ready;
    tick(3);
    seen_ready |= ready;
    chk("t2 ready never", 32'(seen_ready), 32'd0);
    chk("t2 orders", 32'(orders), 32'(o_before));

    // OP1 held through completion: no restart until it drops; then reset mid-cook.
    ops = 4'b0001; tick(1);
    chk("t5 busy", 32'(busy), 32'd1);
    tick(8);
    chk("t5 ready", 32'(ready), 32'd1);
    ack = 1'b1; tick(1); ack = 1'b0;
    chk("t5 clc", 32'(clc), 32'd1);
    chk("t5 orders", 32'(orders), 32'd1);
    tick(5);
    chk("t5 held no restart", {29'(0), busy, ready, clc}, 32'd0);
    ops = 4'b0000; tick(1);
    ops = 4'b0001; tick(1);
    chk("t5 restart after drop", {23'(0), busy, remain}, {23'(0), 1'b1, 8'd8});
    tick(3);
    ops = 4'b0101; tick(1);
    chk("t5 ops ignored in cook", {23'(0), busy, remain}, {23'(0), 1'b1, 8'd4});
    ops = 4'b0000;
    #2 reset = 1'b1;
    #1;
    chk("t5 async reset", {clc, busy, ready, err, dish, remain, orders, 10'(0)}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // ORDERS wraps from 255 to 0.
    for (int i = 0; i < 255; i++) do_order();
    chk("t6 orders 255", 32'(orders), 32'd255);
    do_order();
    chk("t6 orders wrap", 32'(orders), 32'd0);

`ifdef ORDER_TIMER_AUTOACK_EN
    ops = 4'b0010; tick(1); ops = 4'b0000;
    tick(12);
    rc = 0;
    while (ready === 1'b1 && rc < 20) begin rc++; tick(1); end
    chk("t6 autoack ready cycles", 32'(rc), 32'(HOLD));
    chk("t6 autoack clc", 32'(clc), 32'd1);
    chk("t6 autoack orders", 32'(orders), 32'd1);
    tick(2);
`else
    ops = 4'b0010; tick(1); ops = 4'b0000;
    tick(12);
    rc = 0;
    while (ready === 1'b1 && rc < 20) begin rc++; tick(1); end
    chk("t6 no autoack ready held", 32'(rc), 32'd20);
    ack = 1'b1; tick(1); ack = 1'b0;
    chk("t6 late ack orders", 32'(orders), 32'd1);
    tick(2);
`endif

    // Randomized run against the model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      k = $urandom_range(0, 99);
      if (k < 55)      ops = 4'b0000;
      else if (k < 85) ops = 4'(1 << $urandom_range(0, 3));
      else if (k < 90) ops = 4'($urandom_range(0, 15));
      cancel = ($urandom_range(0, 24) == 0);
      ack    = ($urandom_range(0, 3) == 0);
      tick(1);
      model_step(ops, cancel, ack);
      exp_v = {10'(0), (m_phase == 3), (m_phase == 1), (m_phase == 2), m_err,
               2'(m_dish), 8'(m_remain), 8'(m_orders)};
      act_v = {10'(0), clc, busy, ready, err, dish, remain, orders};
      chk($sformatf("rand cyc %0d", cyc), act_v, exp_v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
